// File: rtl/dmem_pkg.sv
// Load/store unit types: FSM state, store-buffer entry, lane helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SDRAIN = 2'd1,
    ST_LOAD   = 2'd2,
    ST_LDONE  = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic [31:0]               addr;
    logic [31:0]               data;
    wishbone_pkg::data_width_e width;
  } sb_entry_t;

  // funct3[1:0] -> bus access width
  function automatic wishbone_pkg::data_width_e func3_width(input logic [1:0] size);
    wishbone_pkg::data_width_e w;
    case (size)
      2'b00:   w = wishbone_pkg::eDW_B;
      2'b01:   w = wishbone_pkg::eDW_H;
      default: w = wishbone_pkg::eDW_W;
    endcase
    return w;
  endfunction

  // Move right-justified store data onto its byte lane
  function automatic logic [31:0] lane_shift(input logic [31:0] data, input logic [1:0] off);
    return data << {off, 3'b000};
  endfunction

  // Pick the addressed byte/half out of the bus word and extend it
  function automatic logic [31:0] load_extract(input logic [2:0]  func3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (func3[1:0])
      2'b00:   res = func3[2] ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   res = func3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wishbone_pkg.sv
// Shared Wishbone data-side types: access width encoding.
package wishbone_pkg;

  typedef enum logic [1:0] {
    eDW_B = 2'd0,
    eDW_H = 2'd1,
    eDW_W = 2'd2
  } data_width_e;

endpackage

// File: rtl/WISHBONE_IF.sv
// Data-side Wishbone bus bundle.
interface WISHBONE_IF;
  logic [31:0]               addr;
  logic                      we;
  logic                      stb;
  logic                      cyc;
  wishbone_pkg::data_width_e width;
  logic [31:0]               data_write;
  logic [31:0]               data_read;
  logic                      ack;

  modport master (output addr, we, stb, cyc, width, data_write, input data_read, ack);
  modport slave  (input addr, we, stb, cyc, width, data_write, output data_read, ack);
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-store FIFO; head entry is read straight from storage flops.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  sb_entry_t                          push_data,
  input  logic                               pop,
  output sb_entry_t                          head,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(SB_DEPTH + 1)-1:0]    count
);

  localparam int unsigned PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int unsigned CW = $clog2(SB_DEPTH + 1);

  sb_entry_t     mem [SB_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SB_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(SB_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: lane steering, posted stores, ordered loads, bus timeout.
module dmem_lsu
  import wishbone_pkg::*;
  import dmem_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic [2:0]  iFunc3,
  input  logic        iEn,
  input  logic        iWrite,
  input  logic [31:0] iAddr,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oStall,
  output logic        oMisalign,
  output logic        oBusErr,
  output logic        oSbEmpty,
  WISHBONE_IF.master  mem_wb
);

  localparam int unsigned CW = $clog2(SB_DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  lsu_state_e    state_q, state_d;
  logic          cyc_q, cyc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   ld_addr_q, ld_addr_d;
  logic [2:0]    ld_func3_q, ld_func3_d;
  logic [31:0]   ld_data_q, ld_data_d;
  logic          bus_err_q, bus_err_d;

  data_width_e   req_width;
  logic          misalign_c;
  logic          st_req;
  logic          ld_req;
  logic          ack_c;
  logic          timeout_c;
  logic          sb_push;
  logic          sb_pop;
  logic          sb_full;
  logic          sb_empty;
  logic [CW-1:0] sb_count;
  sb_entry_t     sb_in;
  sb_entry_t     sb_head;

  // Request decode, alignment and buffer handshake
  always_comb begin
    req_width  = func3_width(iFunc3[1:0]);
    misalign_c = ((req_width == eDW_H) && iAddr[0]) ||
                 ((req_width == eDW_W) && (iAddr[1:0] != 2'b00));
    st_req     = iEn && iWrite && !misalign_c;
    ld_req     = iEn && !iWrite && !misalign_c;
    ack_c      = mem_wb.ack && ((state_q == ST_SDRAIN) || (state_q == ST_LOAD));
    timeout_c  = cyc_q && !ack_c && (tmo_q == TW'(TIMEOUT - 1));
    sb_pop     = (state_q == ST_SDRAIN) && (ack_c || timeout_c);
    sb_push    = st_req && (!sb_full || sb_pop);
    sb_in.addr  = iAddr;
    sb_in.data  = lane_shift(iData, iAddr[1:0]);
    sb_in.width = req_width;
  end

  dmem_store_buffer #(
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk       (iClk),
    .rst_n     (nRst),
    .push      (sb_push),
    .push_data (sb_in),
    .pop       (sb_pop),
    .head      (sb_head),
    .full      (sb_full),
    .empty     (sb_empty),
    .count     (sb_count)
  );

  // Pipeline-facing outputs
  assign oMisalign = iEn && misalign_c;
  assign oStall    = (st_req && sb_full && !sb_pop) || (ld_req && (state_q != ST_LDONE));
  assign oData     = (state_q == ST_LDONE) ? ld_data_q : '0;
  assign oBusErr   = bus_err_q;
  assign oSbEmpty  = sb_empty && (state_q != ST_SDRAIN);

  // Bus outputs come only from flops: state, head entry, held load request
  assign mem_wb.cyc        = cyc_q;
  assign mem_wb.stb        = cyc_q;
  assign mem_wb.we         = cyc_q && (state_q == ST_SDRAIN);
  assign mem_wb.addr       = (state_q == ST_SDRAIN) ? sb_head.addr : ld_addr_q;
  assign mem_wb.width      = (state_q == ST_SDRAIN) ? sb_head.width : func3_width(ld_func3_q[1:0]);
  assign mem_wb.data_write = (state_q == ST_SDRAIN) ? sb_head.data : '0;

  // Next-state, bus-cycle and timeout logic
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    tmo_d      = tmo_q;
    ld_addr_d  = ld_addr_q;
    ld_func3_d = ld_func3_q;
    ld_data_d  = ld_data_q;
    bus_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!sb_empty) begin
          state_d = ST_SDRAIN;
          cyc_d   = 1'b1;
          tmo_d   = '0;
        end else if (ld_req) begin
          state_d    = ST_LOAD;
          cyc_d      = 1'b1;
          tmo_d      = '0;
          ld_addr_d  = iAddr;
          ld_func3_d = iFunc3;
        end
      end
      ST_SDRAIN: begin
        if (ack_c) begin
          tmo_d = '0;
          if (!((sb_count > CW'(1)) || sb_push)) begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
          end
        end else if (timeout_c) begin
          state_d   = ST_IDLE;
          cyc_d     = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_LOAD: begin
        if (ack_c) begin
          state_d   = ST_LDONE;
          cyc_d     = 1'b0;
          tmo_d     = '0;
          ld_data_d = load_extract(ld_func3_q, ld_addr_q[1:0], mem_wb.data_read);
        end else if (timeout_c) begin
          state_d   = ST_LDONE;
          cyc_d     = 1'b0;
          bus_err_d = 1'b1;
          ld_data_d = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_LDONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      cyc_q      <= 1'b0;
      tmo_q      <= '0;
      ld_addr_q  <= '0;
      ld_func3_q <= '0;
      ld_data_q  <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      tmo_q      <= tmo_d;
      ld_addr_q  <= ld_addr_d;
      ld_func3_q <= ld_func3_d;
      ld_data_q  <= ld_data_d;
      bus_err_q  <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a wait-state Wishbone slave model.
module tb_dmem_lsu;
  import wishbone_pkg::*;

  logic        iClk = 1'b0;
  logic        nRst = 1'b0;
  logic [2:0]  iFunc3 = '0;
  logic        iEn = 1'b0;
  logic        iWrite = 1'b0;
  logic [31:0] iAddr = '0;
  logic [31:0] iData = '0;
  logic [31:0] oData;
  logic        oStall;
  logic        oMisalign;
  logic        oBusErr;
  logic        oSbEmpty;

  int          checks = 0;
  int          errors = 0;
  int          ws = 0;
  int          wcnt = 0;
  logic        never_ack = 1'b0;
  logic [31:0] rd_word = '0;
  int          n;
  int          nc;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    data_width_e width;
  } acc_t;
  acc_t log_q[$];

  WISHBONE_IF wb();

  dmem_lsu #(
    .SB_DEPTH (2),
    .TIMEOUT  (4)
  ) dut (
    .iClk      (iClk),
    .nRst      (nRst),
    .iFunc3    (iFunc3),
    .iEn       (iEn),
    .iWrite    (iWrite),
    .iAddr     (iAddr),
    .iData     (iData),
    .oData     (oData),
    .oStall    (oStall),
    .oMisalign (oMisalign),
    .oBusErr   (oBusErr),
    .oSbEmpty  (oSbEmpty),
    .mem_wb    (wb)
  );

  always #5 iClk = ~iClk;

  // Slave: acks after ws wait states unless never_ack
  assign wb.ack       = wb.cyc & wb.stb & ~never_ack & (wcnt == ws);
  assign wb.data_read = rd_word;

  always @(posedge iClk) begin
    if (!(wb.cyc && wb.stb) || wb.ack) wcnt <= 0;
    else                               wcnt <= wcnt + 1;
  end

  // Record every completed access in order
  always @(posedge iClk) begin
    acc_t e;
    if (wb.cyc && wb.stb && wb.ack) begin
      e.we    = wb.we;
      e.addr  = wb.addr;
      e.data  = wb.data_write;
      e.width = wb.width;
      log_q.push_back(e);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge iClk); #1;
  endtask

  task automatic to_check();
    @(negedge iClk);
  endtask

  task automatic set_req(input logic en, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
    iEn = en; iWrite = wr; iFunc3 = f3; iAddr = a; iData = d;
  endtask

  // Single load against an empty buffer and a zero-wait slave
  task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] word, input logic [31:0] exp, input data_width_e w);
    rd_word = word;
    to_drive(); set_req(1'b1, 1'b0, f3, a, '0);
    to_check();
    chk({tag, "_stall_c1"}, 32'(oStall), 32'd1);
    chk({tag, "_misalign"}, 32'(oMisalign), 32'd0);
    to_drive(); to_check();
    chk({tag, "_stall_c2"}, 32'(oStall), 32'd1);
    chk({tag, "_cyc_c2"}, 32'(wb.cyc), 32'd1);
    chk({tag, "_we_c2"}, 32'(wb.we), 32'd0);
    chk({tag, "_addr"}, wb.addr, a);
    chk({tag, "_width"}, 32'(wb.width), 32'(w));
    to_drive(); to_check();
    chk({tag, "_stall_c3"}, 32'(oStall), 32'd0);
    chk({tag, "_data"}, oData, exp);
    chk({tag, "_cyc_c3"}, 32'(wb.cyc), 32'd0);
    to_drive(); iEn = 1'b0;
    to_check();
    chk({tag, "_noreissue"}, 32'(wb.cyc), 32'd0);
    chk({tag, "_data_idle"}, oData, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    to_check();
    chk("rst_data", oData, 32'd0);
    chk("rst_stall", 32'(oStall), 32'd0);
    chk("rst_misalign", 32'(oMisalign), 32'd0);
    chk("rst_buserr", 32'(oBusErr), 32'd0);
    chk("rst_sbempty", 32'(oSbEmpty), 32'd1);
    chk("rst_cyc", 32'(wb.cyc), 32'd0);
    to_drive(); nRst = 1'b1;

    // Loads with sign/zero extension
    load_op("lw", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, eDW_W);
    load_op("lb", 3'b000, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80, eDW_B);
    load_op("lbu", 3'b100, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080, eDW_B);
    load_op("lhu", 3'b101, 32'h0000_0102, 32'h80FF_0000, 32'h0000_80FF, eDW_H);

    // Byte store: lane placement, no stall, drain
    log_q.delete();
    to_drive(); set_req(1'b1, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_0005);
    to_check();
    chk("sb_stall", 32'(oStall), 32'd0);
    chk("sb_empty_c1", 32'(oSbEmpty), 32'd1);
    to_drive(); iEn = 1'b0;
    to_check();
    chk("sb_empty_c2", 32'(oSbEmpty), 32'd0);
    chk("sb_cyc_c2", 32'(wb.cyc), 32'd0);
    to_drive(); to_check();
    chk("sb_cyc_c3", 32'(wb.cyc), 32'd1);
    chk("sb_we_c3", 32'(wb.we), 32'd1);
    chk("sb_addr", wb.addr, 32'h0000_0201);
    chk("sb_wdata", wb.data_write, 32'h0000_0500);
    chk("sb_width", 32'(wb.width), 32'(eDW_B));
    to_drive(); to_check();
    chk("sb_cyc_c4", 32'(wb.cyc), 32'd0);
    chk("sb_empty_c4", 32'(oSbEmpty), 32'd1);
    chk("sb_log_n", 32'(log_q.size()), 32'd1);

    // Two stores then a load, two wait states: stores drain first
    ws = 2;
    log_q.delete();
    rd_word = 32'hCAFE_F00D;
    to_drive(); set_req(1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'h1111_1111);
    to_check(); chk("ord_st1_stall", 32'(oStall), 32'd0);
    to_drive(); set_req(1'b1, 1'b1, 3'b001, 32'h0000_0306, 32'h0000_BEEF);
    to_check(); chk("ord_st2_stall", 32'(oStall), 32'd0);
    to_drive(); set_req(1'b1, 1'b0, 3'b010, 32'h0000_0400, '0);
    to_check();
    n = 0;
    while (oStall && n < 40) begin n++; to_drive(); to_check(); end
    chk("ord_stall_cycles", 32'(n), 32'd10);
    chk("ord_ld_data", oData, 32'hCAFE_F00D);
    to_drive(); iEn = 1'b0;
    chk("ord_log_n", 32'(log_q.size()), 32'd3);
    chk("ord0_we", 32'(log_q[0].we), 32'd1);
    chk("ord0_addr", log_q[0].addr, 32'h0000_0300);
    chk("ord0_data", log_q[0].data, 32'h1111_1111);
    chk("ord1_addr", log_q[1].addr, 32'h0000_0306);
    chk("ord1_data", log_q[1].data, 32'hBEEF_0000);
    chk("ord1_width", 32'(log_q[1].width), 32'(eDW_H));
    chk("ord2_we", 32'(log_q[2].we), 32'd0);
    chk("ord2_addr", log_q[2].addr, 32'h0000_0400);

    // Store into a full buffer stalls until the first ack
    ws = 1;
    log_q.delete();
    to_drive(); set_req(1'b1, 1'b1, 3'b010, 32'h0000_0500, 32'hA5A5_A5A5);
    to_check(); chk("full_st1_stall", 32'(oStall), 32'd0);
    to_drive(); set_req(1'b1, 1'b1, 3'b010, 32'h0000_0504, 32'h5A5A_5A5A);
    to_check(); chk("full_st2_stall", 32'(oStall), 32'd0);
    to_drive(); set_req(1'b1, 1'b1, 3'b010, 32'h0000_0508, 32'h0F0F_0F0F);
    to_check();
    chk("full_st3_stall", 32'(oStall), 32'd1);
    chk("full_st3_noack", 32'(wb.ack), 32'd0);
    to_drive(); to_check();
    chk("full_ack_stall", 32'(oStall), 32'd0);
    chk("full_ack_seen", 32'(wb.ack), 32'd1);
    to_drive(); iEn = 1'b0;
    to_check();
    n = 0;
    while (!oSbEmpty && n < 30) begin n++; to_drive(); to_check(); end
    chk("full_drained", 32'(oSbEmpty), 32'd1);
    chk("full_log_n", 32'(log_q.size()), 32'd3);
    chk("full0_addr", log_q[0].addr, 32'h0000_0500);
    chk("full1_addr", log_q[1].addr, 32'h0000_0504);
    chk("full2_addr", log_q[2].addr, 32'h0000_0508);
    chk("full2_data", log_q[2].data, 32'h0F0F_0F0F);
    ws = 0;

    // Misaligned word store and half load
    to_drive(); set_req(1'b1, 1'b1, 3'b010, 32'h0000_0102, 32'h1234_5678);
    to_check();
    chk("mis_sw_flag", 32'(oMisalign), 32'd1);
    chk("mis_sw_stall", 32'(oStall), 32'd0);
    chk("mis_sw_data", oData, 32'd0);
    to_drive(); set_req(1'b1, 1'b0, 3'b001, 32'h0000_0101, '0);
    to_check();
    chk("mis_lh_flag", 32'(oMisalign), 32'd1);
    chk("mis_lh_stall", 32'(oStall), 32'd0);
    chk("mis_lh_data", oData, 32'd0);
    chk("mis_sw_nocyc", 32'(wb.cyc), 32'd0);
    chk("mis_sw_noenq", 32'(oSbEmpty), 32'd1);
    to_drive(); iEn = 1'b0;
    to_check();
    chk("mis_lh_nocyc", 32'(wb.cyc), 32'd0);
    chk("mis_clear", 32'(oMisalign), 32'd0);

    // Load timeout with a silent slave
    never_ack = 1'b1;
    to_drive(); set_req(1'b1, 1'b0, 3'b010, 32'h0000_0600, '0);
    to_check();
    n = 0; nc = 0;
    while (oStall && n < 40) begin
      n++;
      if (wb.cyc) nc++;
      to_drive(); to_check();
    end
    chk("tmo_stall_cycles", 32'(n), 32'd5);
    chk("tmo_cyc_cycles", 32'(nc), 32'd4);
    chk("tmo_buserr", 32'(oBusErr), 32'd1);
    chk("tmo_data", oData, 32'd0);
    chk("tmo_cyc_dropped", 32'(wb.cyc), 32'd0);
    to_drive(); iEn = 1'b0;
    to_check();
    chk("tmo_buserr_pulse", 32'(oBusErr), 32'd0);

    // Reset in the middle of a store drain
    to_drive(); set_req(1'b1, 1'b1, 3'b010, 32'h0000_0700, 32'h0000_0077);
    to_check(); chk("rstd_stall", 32'(oStall), 32'd0);
    to_drive(); iEn = 1'b0;
    to_check(); chk("rstd_cyc_c2", 32'(wb.cyc), 32'd0);
    to_drive(); to_check();
    chk("rstd_cyc_c3", 32'(wb.cyc), 32'd1);
    chk("rstd_we_c3", 32'(wb.we), 32'd1);
    #2; nRst = 1'b0;
    #1;
    chk("rstd_cyc_async", 32'(wb.cyc), 32'd0);
    chk("rstd_stb_async", 32'(wb.stb), 32'd0);
    chk("rstd_we_async", 32'(wb.we), 32'd0);
    to_drive(); nRst = 1'b1; never_ack = 1'b0;
    to_check();
    chk("rstd_sbempty", 32'(oSbEmpty), 32'd1);
    chk("rstd_cyc_after", 32'(wb.cyc), 32'd0);
    to_drive(); to_check();
    chk("rstd_no_drain", 32'(wb.cyc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Parametrised load/store unit between the MEM pipeline stage and the data-side Wishbone bus; successor to the combinational data memory interface.
Adds byte-lane steering of store/load data, true zero-extension for LBU/LHU, misalignment detection, and a posted-store buffer of configurable depth.
Adds a registered bus FSM with an ack timeout.
Loads are strictly ordered behind buffered stores.

Parameters:
SB_DEPTH, 2, posted-store buffer entries (power of 2, >=1)
TIMEOUT, 255, cycles without ack before a bus access is abandoned (>=1)

Ports:
iClk  input  1  clock
nRst  input  1  asynchronous active-low reset
iFunc3  input  3  RV32 load/store funct3
iEn  input  1  memory op request; held stable with iWrite/iAddr/iData while oStall=1
iWrite  input  1  1=store, 0=load
iAddr  input  32  byte address
iData  input  32  store data, right-justified
oData  output  32  load result, extended per iFunc3
oStall  output  1  pipeline stall
oMisalign  output  1  misaligned access flag, combinational
oBusErr  output  1  one-cycle pulse on access timeout
oSbEmpty  output  1  store buffer empty (for FENCE)
mem_wb  WISHBONE_IF.master  -  data bus: addr, we, stb, cyc, width, data_write, data_read, ack

Behaviour:
- Reset:
  - One clock. Reset is asynchronous and active-low.
  - Assertion immediately drops cyc/stb/we, flushes the buffer, clears the timeout counter and enters IDLE.
  - Reset values: oData=0, oStall=0, oMisalign=0, oBusErr=0, oSbEmpty=1.
- Width:
  - iFunc3[1:0]: 00=byte (eDW_B), 01=half (eDW_H), 1x=word (eDW_W).
  - iFunc3[2]=1 selects zero-extension.
- Misalignment:
  - Condition: half with iAddr[0]=1, or word with iAddr[1:0]!=0.
  - oMisalign=iEn that cycle; oStall=0; oData=0.
  - No enqueue, no bus access.
- Lane placement:
  - Store data is shifted left by 8*iAddr[1:0] before enqueue.
  - mem_wb.addr = full iAddr.
  - Loads extract the byte/half at lane iAddr[1:0] from data_read, then sign- or zero-extend.
- Stores (posted):
  - iEn&iWrite, aligned, buffer not full: enqueue {addr, lane data, width} on this edge; oStall=0.
  - Buffer full: oStall=1 until a pop frees a slot. Enqueue and pop in the same cycle is legal; count unchanged.
- FSM states: IDLE, SDRAIN, LOAD, LDONE.
- IDLE:
  - Buffer non-empty -> SDRAIN.
  - Else aligned load pending -> LOAD.
  - A load seen in IDLE drives oStall=1.
- SDRAIN:
  - Drives cyc=stb=we=1 with head entry fields from registers.
  - On ack: pop; stay in SDRAIN if further entries remain (back-to-back), else IDLE.
- LOAD:
  - Drives cyc=stb=1, we=0, addr/width from the held request; oStall=1.
  - On ack: register extracted data -> LDONE.
- LDONE:
  - oStall=0, oData=registered value.
  - Bus idle; must not re-issue although iEn is still high.
  - Next cycle -> IDLE.
- Load latency: zero-wait slave with empty buffer = 3 cycles (IDLE, LOAD+ack, LDONE). Each buffered store adds at least 1 cycle.
- Timeout:
  - Counter resets on entering SDRAIN/LOAD and on each ack; counts while cyc is high.
  - At TIMEOUT: drop cyc/stb and pulse oBusErr.
  - SDRAIN: pops the entry.
  - LOAD: -> LDONE with oData=0.
- Bus protocol: cyc=stb at all times; outputs are registered/stable for the whole access; ack is ignored outside SDRAIN/LOAD.
- oSbEmpty = (count==0) and state!=SDRAIN.

Decomposition:
- Package dmem_pkg:
  - State enum.
  - sb_entry_t struct {addr[31:0], data[31:0], width}.
  - Functions lane_shift() and load_extract(func3, off, word).
  - Width enum reused from the Wishbone package.
- Sub-module dmem_store_buffer: synchronous FIFO of sb_entry_t, parameter SB_DEPTH, with push/pop/full/empty/count and async active-low reset.

Test Plan:
- Zero-wait slave, load LW 0x100 holding 0xDEADBEEF -> oStall 1,1,0; oData=0xDEADBEEF in LDONE cycle.
- LB 0x103 on word 0x80FF_0000 -> oData=0xFFFFFF80; LBU same -> 0x00000080; LHU 0x102 -> 0x000080FF.
- SB 0x05 to 0x201 -> data_write=0x00000500, width=eDW_B, addr=0x201; no stall on enqueue.
- Two stores then load, slave 2 wait states -> both stores drain in order before the load.
- Store while full -> oStall=1 until first ack.
- SW to 0x102 -> oMisalign=1, oStall=0, no cyc; LH 0x101 likewise.
- Slave never acks, TIMEOUT=4 -> load drops cyc after 4 cycles, oBusErr single pulse, oData=0.
- nRst low mid-SDRAIN -> cyc=0 immediately; oSbEmpty=1 after release.
